// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch: PC, imem req/gnt/rvalid, in-order buffer toward decode
// Optional misaligned-redirect fault: FETCH_ALIGN_CHECK_EN.
module fetch_unit #(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH     = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic        fetch_fault_o
`endif
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;
  localparam ptr_t PTR_ONE   = ptr_t'(1);
  localparam cnt_t CNT_ONE   = cnt_t'(1);
  localparam cnt_t CNT_DEPTH = cnt_t'(DEPTH);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_FLUSH} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  cnt_t        out_q, out_d;
  cnt_t        stale_q, stale_d;
  cnt_t        cnt_q, cnt_d;
  ptr_t        fifo_rd_q, fifo_rd_d, fifo_wr_q, fifo_wr_d;
  ptr_t        rq_rd_q, rq_rd_d, rq_wr_q, rq_wr_d;
  logic [31:0] fifo_inst_q [DEPTH];
  logic [31:0] fifo_inst_d [DEPTH];
  logic [31:0] fifo_pc_q [DEPTH];
  logic [31:0] fifo_pc_d [DEPTH];
  logic [31:0] rq_pc_q [DEPTH];
  logic [31:0] rq_pc_d [DEPTH];
  logic        fault_q, fault_d;

  logic        redirect_act, redirect_bad;
  logic [31:0] redirect_tgt;
  logic [CW:0] inflight;
  logic        credit_ok, gnt_fire, rsp_stale, rsp_live, push_fire, pop_fire;

`ifdef FETCH_ALIGN_CHECK_EN
  assign redirect_tgt  = redirect_pc_i;
  assign redirect_bad  = |redirect_pc_i[1:0];
  assign fetch_fault_o = fault_q;
`else
  assign redirect_tgt  = redirect_pc_i & 32'hFFFF_FFFC;
  assign redirect_bad  = 1'b0;
`endif

  // Credits cover both words in flight and words already buffered, so a push never overflows.
  assign inflight     = {1'b0, out_q} + {1'b0, cnt_q};
  assign credit_ok    = inflight < {1'b0, CNT_DEPTH};
  assign redirect_act = redirect_i && (state_q != S_BOOT);
  assign imem_req_o   = (state_q == S_RUN) && credit_ok && !redirect_i && !fault_q;
  assign imem_addr_o  = pc_q;
  assign gnt_fire     = imem_req_o && imem_gnt_i;
  assign rsp_stale    = imem_rvalid_i && (stale_q != '0);
  assign rsp_live     = imem_rvalid_i && (stale_q == '0);
  assign push_fire    = rsp_live && !redirect_act;
  assign inst_valid_o = (cnt_q != '0);
  assign pop_fire     = inst_valid_o && inst_ready_i;
  assign inst_o       = fifo_inst_q[fifo_rd_q];
  assign pc_o         = fifo_pc_q[fifo_rd_q];

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    out_d       = out_q;
    stale_d     = stale_q;
    cnt_d       = cnt_q;
    fifo_rd_d   = fifo_rd_q;
    fifo_wr_d   = fifo_wr_q;
    rq_rd_d     = rq_rd_q;
    rq_wr_d     = rq_wr_q;
    fifo_inst_d = fifo_inst_q;
    fifo_pc_d   = fifo_pc_q;
    rq_pc_d     = rq_pc_q;
    fault_d     = fault_q;

    if (gnt_fire) begin
      pc_d             = pc_q + 32'd4;
      rq_pc_d[rq_wr_q] = pc_q;
      rq_wr_d          = rq_wr_q + PTR_ONE;
    end
    if (rsp_stale) stale_d = stale_q - CNT_ONE;
    if (rsp_live) rq_rd_d = rq_rd_q + PTR_ONE;
    if (push_fire) begin
      fifo_inst_d[fifo_wr_q] = imem_rdata_i;
      fifo_pc_d[fifo_wr_q]   = rq_pc_q[rq_rd_q];
      fifo_wr_d              = fifo_wr_q + PTR_ONE;
    end
    if (pop_fire) fifo_rd_d = fifo_rd_q + PTR_ONE;
    out_d = out_q + cnt_t'(gnt_fire) - cnt_t'(rsp_live);
    cnt_d = cnt_q + cnt_t'(push_fire) - cnt_t'(pop_fire);

    case (state_q)
      S_BOOT:  state_d = S_RUN;
      S_RUN:   state_d = S_RUN;
      S_FLUSH: if (stale_d == '0) state_d = S_RUN;
      default: state_d = S_BOOT;
    endcase

    // Every in-flight request becomes stale; a response landing now has already been consumed.
    if (redirect_act) begin
      cnt_d     = '0;
      fifo_rd_d = '0;
      fifo_wr_d = '0;
      rq_rd_d   = '0;
      rq_wr_d   = '0;
      out_d     = '0;
      stale_d   = stale_q + out_q + cnt_t'(gnt_fire) - cnt_t'(imem_rvalid_i);
      pc_d      = redirect_tgt;
      fault_d   = redirect_bad;
      state_d   = ((state_q == S_FLUSH) || (stale_d != '0)) ? S_FLUSH : S_RUN;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_BOOT;
      pc_q        <= BOOT_ADDR;
      out_q       <= '0;
      stale_q     <= '0;
      cnt_q       <= '0;
      fifo_rd_q   <= '0;
      fifo_wr_q   <= '0;
      rq_rd_q     <= '0;
      rq_wr_q     <= '0;
      fifo_inst_q <= '{default: '0};
      fifo_pc_q   <= '{default: '0};
      rq_pc_q     <= '{default: '0};
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      out_q       <= out_d;
      stale_q     <= stale_d;
      cnt_q       <= cnt_d;
      fifo_rd_q   <= fifo_rd_d;
      fifo_wr_q   <= fifo_wr_d;
      rq_rd_q     <= rq_rd_d;
      rq_wr_q     <= rq_wr_d;
      fifo_inst_q <= fifo_inst_d;
      fifo_pc_q   <= fifo_pc_d;
      rq_pc_q     <= rq_pc_d;
      fault_q     <= fault_d;
    end
  end

  no_push_when_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push_fire && (cnt_q == CNT_DEPTH) && !pop_fire));

endmodule
